// File: rtl/column_scanner_if.sv
// Bus bundle for column_scanner: scan controls in, registered column drive out.
// The driving side uses the master modport and the scanner uses the slave modport.
interface column_scanner_if #(
  parameter int N     = 6,
  parameter int DIV_W = 8
);
  localparam int IDX_W = (N <= 2) ? 1 : $clog2(N);

  logic             en;
  logic             dir;
  logic [DIV_W-1:0] div;
  logic             sync;
  logic [N-1:0]     q;
  logic [IDX_W-1:0] col_idx;
  logic             step;
  logic             frame;
  logic             running;

  // Handshake: there is no back-pressure. Control inputs are sampled on every
  // rising clock edge. step marks each cycle that carries a new column value,
  // frame marks the cycles where that value is the start column, and running
  // shows the FSM state (1 = RUN).
  modport master (
    output en, dir, div, sync,
    input  q, col_idx, step, frame, running
  );

  modport slave (
    input  en, dir, div, sync,
    output q, col_idx, step, frame, running
  );
endinterface

// File: rtl/column_scanner.sv
// One-hot LED column scanner with a programmable step divider, a scan direction
// and a sync pulse that restarts the frame. All outputs are registered.
module column_scanner #(
  parameter int N     = 6,
  parameter int DIV_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  column_scanner_if.slave bus
);
  localparam int IDX_W = (N <= 2) ? 1 : $clog2(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [N-1:0]     Q_ONE = N'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_n;
  logic [DIV_W-1:0] cnt_r, cnt_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [N-1:0]     q_r, q_n;
  logic             step_r, step_n;
  logic             frame_r, frame_n;
  logic [IDX_W-1:0] start_col, adv_col;

  // The start column and the step direction follow the live dir input, so a
  // direction change affects only the next advance.
  always_comb begin
    start_col = bus.dir ? LAST : '0;
    if (bus.dir) adv_col = (idx_r == '0)   ? LAST : idx_r - IDX_W'(1);
    else         adv_col = (idx_r == LAST) ? '0   : idx_r + IDX_W'(1);
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    step_n  = 1'b0;
    frame_n = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (bus.en) begin
          state_n = RUN;
          idx_n   = start_col;
          step_n  = 1'b1;
          frame_n = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (bus.sync) begin
          cnt_n   = '0;
          idx_n   = start_col;
          step_n  = 1'b1;
          frame_n = 1'b1;
        end else if (cnt_r >= bus.div) begin
          // >= rather than == so that lowering div below cnt advances at once.
          cnt_n   = '0;
          idx_n   = adv_col;
          step_n  = 1'b1;
          frame_n = (adv_col == start_col);
        end else begin
          cnt_n = cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
    q_n = (state_n == RUN) ? (Q_ONE << idx_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      q_r     <= '0;
      step_r  <= 1'b0;
      frame_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      q_r     <= q_n;
      step_r  <= step_n;
      frame_r <= frame_n;
    end
  end

  assign bus.q       = q_r;
  assign bus.col_idx = idx_r;
  assign bus.step    = step_r;
  assign bus.frame   = frame_r;
  assign bus.running = (state_r == RUN);
endmodule
